// File: rtl/fir_pkg.sv
// Shared definitions for the symmetric FIR datapath.
//   SAMPLE_W  : sample width; matches the pre-adder operand width
//   TAPS_DEF  : default delay-line depth
//   state_t   : sequencer FSM states
package fir_pkg;
  localparam int SAMPLE_W = 17;
  localparam int TAPS_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;
endpackage

// File: rtl/fir_delay_line.sv
// Parameterised shift register with a shift enable, a synchronous clear and
// two combinational read ports addressed by index. d[0] is the newest sample.
// Ports:
//   clk            rising-edge clock
//   clr            synchronous clear of every stage to zero
//   shift          shift din into d[0], d[i] <= d[i-1]
//   din            sample to insert
//   addr_a/addr_b  read indices
//   dout_a/dout_b  d[addr_a] / d[addr_b]
module fir_delay_line #(
  parameter int TAPS = 16,
  parameter int W    = 17,
  parameter int AW   = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          shift,
  input  logic [W-1:0]  din,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  output logic [W-1:0]  dout_a,
  output logic [W-1:0]  dout_b
);

  logic [W-1:0] d [TAPS];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < TAPS; i++) d[i] <= '0;
    end else if (shift) begin
      d[0] <= din;
      for (int i = 1; i < TAPS; i++) d[i] <= d[i-1];
    end
  end

  assign dout_a = d[addr_a];
  assign dout_b = d[addr_b];

endmodule

// File: rtl/fir_tap_pair_sequencer.sv
// Upstream stage of the symmetric FIR: keeps the last TAPS samples and, for
// each accepted sample, emits the TAPS/2 symmetric pairs (x[k], x[TAPS-1-k])
// one per handshake. Input is throttled until a sample's pairs are all sent.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   clr                  synchronous flush of delay line and sequence
//   in_valid/in_ready    sample input handshake, in_sample is the sample
//   pair_valid/ready     pair output handshake
//   pair_a, pair_b       x[idx], x[TAPS-1-idx] (idx 0 = newest)
//   pair_idx, pair_last  current pair index; high with the final pair
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high; a producer holds valid and its data stable until that transfer.
module fir_tap_pair_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS     = fir_pkg::TAPS_DEF,
  parameter int SAMPLE_W = fir_pkg::SAMPLE_W,
  parameter int IDX_W    = $clog2(TAPS/2)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_sample,
  output logic                pair_valid,
  input  logic                pair_ready,
  output logic [SAMPLE_W-1:0] pair_a,
  output logic [SAMPLE_W-1:0] pair_b,
  output logic [IDX_W-1:0]    pair_idx,
  output logic                pair_last
);

  localparam int AW   = $clog2(TAPS);
  localparam int LAST = TAPS/2 - 1;

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [SAMPLE_W-1:0]   a_q;
  logic [SAMPLE_W-1:0]   b_q;
  logic                  valid_q;
  logic                  accept;
  logic                  at_last;
  logic [AW-1:0]         addr_a;
  logic [AW-1:0]         addr_b;
  logic [SAMPLE_W-1:0]   dout_a;
  logic [SAMPLE_W-1:0]   dout_b;

  assign in_ready = (state == IDLE) & ~rst & ~clr;
  assign accept   = in_ready & in_valid;
  assign at_last  = (idx == IDX_W'(LAST));

  // In EMIT the read ports look ahead to the next pair (idx+1). In IDLE the
  // line has not shifted yet, so the oldest surviving sample after the shift
  // is the current d[TAPS-2]; the newest comes straight from in_sample.
  assign addr_a = AW'(idx) + AW'(1);
  assign addr_b = (state == IDLE) ? AW'(TAPS-2) : (AW'(TAPS-2) - AW'(idx));

  fir_delay_line #(
    .TAPS (TAPS),
    .W    (SAMPLE_W),
    .AW   (AW)
  ) u_line (
    .clk    (clk),
    .clr    (rst | clr),
    .shift  (accept),
    .din    (in_sample),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .dout_a (dout_a),
    .dout_b (dout_b)
  );

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state   <= IDLE;
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_sample;
            b_q     <= dout_b;
            idx     <= '0;
            valid_q <= 1'b1;
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (pair_ready) begin
            if (at_last) begin
              valid_q <= 1'b0;
              state   <= IDLE;
            end else begin
              idx <= idx + 1'b1;
              a_q <= dout_a;
              b_q <= dout_b;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pair_valid = valid_q;
  assign pair_a     = a_q;
  assign pair_b     = b_q;
  assign pair_idx   = idx;
  assign pair_last  = valid_q & at_last;

endmodule
